// File: rtl/load_store_unit.sv
// Load/store unit: serialises one RV32I load/store into little-endian byte accesses
// on a byte-wide acked memory, returning extended load data or an error response.
module load_store_unit #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_func3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state, state_nxt;
   logic [1:0]      k, last_k;
   logic            op_we;
   logic [2:0]      op_f3;
   logic [3:0][7:0] op_wb;
   logic [3:0][7:0] rbuf, word;
   logic [31:0]     load_val;
   logic            accept, req_bad, last_ack;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign last_k    = (op_f3[1:0] == 2'b00) ? 2'd0 : (op_f3[1:0] == 2'b01) ? 2'd1 : 2'd3;
   assign last_ack  = (state == ACCESS) && mem_ack && (k == last_k);

   // Size-based alignment plus the funct3 codes that have no load/store meaning.
   always_comb begin
      req_bad = 1'b0;
      case (req_func3[1:0])
         2'b00:   req_bad = 1'b0;
         2'b01:   req_bad = req_addr[0];
         2'b10:   req_bad = (req_addr[1:0] != 2'b00);
         default: req_bad = 1'b1;
      endcase
      if (req_we && req_func3[2])
         req_bad = 1'b1;
      if (!req_we && (req_func3[2:1] == 2'b11))
         req_bad = 1'b1;
   end

   // Final byte arrives on the same edge that completes the load.
   always_comb begin
      word    = rbuf;
      word[k] = mem_rdata;
      case (op_f3)
         3'b000:  load_val = {{24{word[0][7]}}, word[0]};
         3'b001:  load_val = {{16{word[1][7]}}, word[1], word[0]};
         3'b100:  load_val = {24'd0, word[0]};
         3'b101:  load_val = {16'd0, word[1], word[0]};
         default: load_val = word;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_bad ? DONE : ACCESS;
         ACCESS:  if (last_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k         <= 2'd0;
         op_we     <= 1'b0;
         op_f3     <= 3'd0;
         op_wb     <= '0;
         rbuf      <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  k     <= 2'd0;
                  rbuf  <= '0;
                  op_we <= req_we;
                  op_f3 <= req_func3;
                  op_wb <= req_wdata;
                  if (req_bad) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'd0;
                  end else begin
                     mem_en    <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata[7:0];
                  end
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  rbuf <= word;
                  if (k == last_k) begin
                     mem_en    <= 1'b0;
                     mem_we    <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= op_we ? 32'd0 : load_val;
                  end else begin
                     k         <= k + 2'd1;
                     mem_addr  <= mem_addr + 1'b1;
                     mem_wdata <= op_wb[k + 2'd1];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: a byte-memory responder with programmable
// ack stalls, and an array-based reference model predicting data, error and latency.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_func3 = 3'd0;
   logic [7:0]  req_addr = 8'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we;
   logic [31:0] rsp_rdata;
   logic [7:0]  mem_addr, mem_wdata;
   logic [7:0]  mem_rdata = 8'd0;
   logic        mem_ack = 1'b0;

   load_store_unit #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] rdata; logic err; int acc_edge; int lat;} exp_t;
   typedef struct {logic we; logic [7:0] addr; logic [7:0] data;} acc_t;

   exp_t        rq[$];
   acc_t        aq[$];
   logic [7:0]  tbmem[256];
   logic [7:0]  refmem[256];
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, stall = 0, mcnt = 0, n_acc = 0, n_rsp = 0;
   logic [31:0] last_rsp = 32'd0;
   logic        last_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: what an RV32I load/store does to a flat byte array.
   task automatic model_accept(input logic we, input logic [2:0] f3, input logic [7:0] a,
                               input logic [31:0] d);
      exp_t e;
      acc_t x;
      int n;
      logic bad;
      logic [31:0] v;
      n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      bad = (f3[1:0] == 2'd3) || (!we && f3 >= 3'd6) || (we && f3 >= 3'd4) ||
            (a % n != 0);
      e.acc_edge = cyc + 1;
      e.err      = bad;
      e.rdata    = 32'd0;
      e.lat      = bad ? 1 : 1 + n * (stall + 1);
      if (!bad) begin
         v = 32'd0;
         for (int i = 0; i < n; i++) begin
            x.we   = we;
            x.addr = 8'((int'(a) + i) % 256);
            x.data = 8'(d >> (8 * i));
            aq.push_back(x);
            if (we) refmem[x.addr] = x.data;
            else    v = v | (32'(refmem[x.addr]) << (8 * i));
         end
         if (!we) begin
            case (f3)
               3'd0:    v = 32'($signed(v[7:0]));
               3'd1:    v = 32'($signed(v[15:0]));
               default: ;
            endcase
            e.rdata = v;
         end
      end
      rq.push_back(e);
      n_acc++;
   endtask

   // Monitor, scoreboard and memory responder, all on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         rq.delete();
         aq.delete();
         last_rsp = 32'd0;
         mem_ack  = 1'b0;
         mcnt     = 0;
      end else begin
         if (req_valid && req_ready)
            model_accept(req_we, req_func3, req_addr, req_wdata);
         if (rsp_valid) begin
            n_rsp++;
            if (rq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL spurious_rsp: got rsp_valid with rdata %h, expected none", rsp_rdata);
            end else begin
               exp_t e;
               e = rq.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", 32'(rsp_err), 32'(e.err));
               check("latency", 32'(cyc - e.acc_edge + 1), 32'(e.lat));
            end
            last_rsp = rsp_rdata;
            last_err = rsp_err;
         end else begin
            check("rdata_held", rsp_rdata, last_rsp);
         end
         if (mem_en) begin
            check("ready_low_busy", 32'(req_ready), 32'd0);
            if (mcnt >= stall) begin
               mem_ack = 1'b1;
               mcnt    = 0;
               if (aq.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_access: got mem access at %h, expected none", mem_addr);
               end else begin
                  acc_t x;
                  x = aq.pop_front();
                  check("mem_addr", 32'(mem_addr), 32'(x.addr));
                  check("mem_we", 32'(mem_we), 32'(x.we));
                  if (x.we) check("mem_wdata", 32'(mem_wdata), 32'(x.data));
               end
               if (mem_we) tbmem[mem_addr] = mem_wdata;
               mem_rdata = tbmem[mem_addr];
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = 8'($urandom);
               mcnt++;
            end
         end else begin
            mem_ack = 1'b0;
            mcnt    = 0;
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] d);
      @(posedge clk) #1;
      req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = d;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (req_ready) break;
         if (t == 299) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: got req_ready low, expected acceptance");
         end
      end
      @(posedge clk) #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int t = 0; t < 300; t++) begin
         @(posedge clk) #2;
         if (rq.size() == 0 && req_ready && !mem_en) return;
      end
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got %0d pending responses, expected 0", rq.size());
   endtask

   initial begin
      int a0, r0, diffs;
      logic [7:0] a;
      logic [2:0] f;
      for (int i = 0; i < 256; i++) begin
         tbmem[i]  = 8'($urandom);
         refmem[i] = tbmem[i];
      end
      repeat (3) @(posedge clk);
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      @(posedge clk) #1;
      rst = 1'b0;

      // SW then LW, ack tied high
      stall = 0;
      issue(1'b1, 3'b010, 8'h10, 32'hA1B2C3D4); wait_done();
      issue(1'b0, 3'b010, 8'h10, 32'h0);        wait_done();
      check("sw_b0", 32'(tbmem[8'h10]), 32'hD4);
      check("sw_b1", 32'(tbmem[8'h11]), 32'hC3);
      check("sw_b2", 32'(tbmem[8'h12]), 32'hB2);
      check("sw_b3", 32'(tbmem[8'h13]), 32'hA1);
      check("lw_data", last_rsp, 32'hA1B2C3D4);

      // sign/zero extension
      tbmem[8'h21] = 8'h80; refmem[8'h21] = 8'h80;
      tbmem[8'h20] = 8'h34; refmem[8'h20] = 8'h34;
      issue(1'b0, 3'b000, 8'h21, 32'h0); wait_done(); check("lb_80", last_rsp, 32'hFFFFFF80);
      issue(1'b0, 3'b100, 8'h21, 32'h0); wait_done(); check("lbu_80", last_rsp, 32'h00000080);
      issue(1'b0, 3'b001, 8'h20, 32'h0); wait_done(); check("lh_8034", last_rsp, 32'hFFFF8034);

      // misaligned / illegal
      issue(1'b0, 3'b010, 8'h02, 32'h0); wait_done(); check("lw_mis_err", 32'(last_err), 32'd1);
      issue(1'b0, 3'b001, 8'h05, 32'h0); wait_done(); check("lh_mis_err", 32'(last_err), 32'd1);
      issue(1'b0, 3'b011, 8'h08, 32'h0); wait_done(); check("f3_011_err", 32'(last_err), 32'd1);
      check("err_rdata", last_rsp, 32'd0);

      // SH across the top of memory with 3-cycle ack stalls
      stall = 3;
      issue(1'b1, 3'b001, 8'hFE, 32'h0000BEEF); wait_done();
      check("sh_fe", 32'(tbmem[8'hFE]), 32'hEF);
      check("sh_ff", 32'(tbmem[8'hFF]), 32'hBE);

      // reset in the middle of an LW
      stall = 2;
      r0 = n_rsp;
      issue(1'b0, 3'b010, 8'h40, 32'h0);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (mem_en && mem_addr == 8'h41) break;
      end
      @(posedge clk) #1;
      rst = 1'b1;
      #1;
      check("rst_mid_mem_en", 32'(mem_en), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk) #1;
      rst = 1'b0;
      check("rst_mid_no_rsp", 32'(n_rsp), 32'(r0));
      stall = 0;
      issue(1'b0, 3'b000, 8'h21, 32'h0); wait_done(); check("lb_after_rst", last_rsp, 32'hFFFFFF80);

      // req_valid held high with alternating LB/SB
      a0 = n_acc; r0 = n_rsp;
      @(posedge clk) #1;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_we = i[0]; req_func3 = 3'b000;
         req_addr = 8'($urandom); req_wdata = $urandom;
         for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready) break;
         end
         @(posedge clk) #1;
      end
      req_valid = 1'b0;
      wait_done();
      check("b2b_accepts", 32'(n_acc - a0), 32'd10);
      check("b2b_rsps", 32'(n_rsp - r0), 32'd10);

      // random mix including illegal codes and misaligned addresses
      for (int i = 0; i < 40; i++) begin
         stall = $urandom_range(0, 2);
         f = 3'($urandom);
         a = 8'($urandom);
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         issue(1'($urandom), f, a, $urandom);
         wait_done();
      end

      diffs = 0;
      for (int i = 0; i < 256; i++)
         if (tbmem[i] !== refmem[i]) diffs++;
      check("mem_image", 32'(diffs), 32'd0);
      check("rsp_queue_empty", 32'(rq.size()), 32'd0);
      check("acc_queue_empty", 32'(aq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
